// File: rtl/data_mem_responder_if.sv
// Request/response channel between the core's load/store unit and the data memory.
// Signal suffixes are from the responder's point of view.
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic        req_byte_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport slave (
    input  req_valid_i, req_write_i, req_byte_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_write_i, req_byte_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM serving LW/LBU/SW/SB one request at a time,
// with a programmable access latency to exercise the core's stall path.
module data_mem_responder #(
  parameter int ADDR_WIDTH_P  = 10,
  parameter int WAIT_CYCLES_P = 1
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH_P;
  localparam int          AW       = ADDR_WIDTH_P + 2;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES_P - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH_P-1:0] word_idx;
  logic [1:0]              lane;
  logic                    misaligned;
  logic                    commit;
  logic [31:0]             mem_word;
  logic [31:0]             lane_shifted;
  logic [31:0]             wr_word;
  logic [3:0]              be;
  logic                    unused_addr;

  // Only the bits that select a word and a lane matter; the rest wrap.
  assign unused_addr  = ^bus.req_addr_i[31:AW];

  assign word_idx     = addr_q[AW-1:2];
  assign lane         = addr_q[1:0];
  assign misaligned   = ~byte_q & (lane != 2'd0);
  assign commit       = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_word     = mem[word_idx];
  assign lane_shifted = mem_word >> {lane, 3'b000};
  assign wr_word      = byte_q ? {4{wdata_q[7:0]}} : wdata_q;

  always_comb begin
    be = 4'b0000;
    if (commit && write_q && !reset) begin
      if (byte_q)           be = 4'b0001 << lane;
      else if (!misaligned) be = 4'b1111;
    end
  end

  // NOTE: the RAM has no reset branch so it maps onto block RAM; contents after reset are whatever was last written.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          write_d = bus.req_write_i;
          byte_d  = bus.req_byte_i;
          addr_d  = bus.req_addr_i[AW-1:0];
          wdata_d = bus.req_wdata_i;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          err_d   = misaligned;
          if (write_q || misaligned) rdata_d = '0;
          else if (byte_q)           rdata_d = {24'b0, lane_shifted[7:0]};
          else                       rdata_d = mem_word;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready_i) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready_o  = (state_q == IDLE);
  assign bus.resp_valid_o = (state_q == RESP);
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut0 uses default parameters, dut1 uses WAIT_CYCLES_P=3, ADDR_WIDTH_P=4.
module tb_data_mem_responder;

  logic        clk;
  logic [1:0]  rst;
  logic        req_valid  [2];
  logic        req_write  [2];
  logic        req_byte   [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_ready [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int total = 0;
  int bad   = 0;

  data_mem_responder_if if0 ();
  data_mem_responder_if if1 ();

  assign if0.req_valid_i  = req_valid[0];
  assign if0.req_write_i  = req_write[0];
  assign if0.req_byte_i   = req_byte[0];
  assign if0.req_addr_i   = req_addr[0];
  assign if0.req_wdata_i  = req_wdata[0];
  assign if0.resp_ready_i = resp_ready[0];
  assign req_ready[0]     = if0.req_ready_o;
  assign resp_valid[0]    = if0.resp_valid_o;
  assign resp_rdata[0]    = if0.resp_rdata_o;
  assign resp_err[0]      = if0.resp_err_o;

  assign if1.req_valid_i  = req_valid[1];
  assign if1.req_write_i  = req_write[1];
  assign if1.req_byte_i   = req_byte[1];
  assign if1.req_addr_i   = req_addr[1];
  assign if1.req_wdata_i  = req_wdata[1];
  assign if1.resp_ready_i = resp_ready[1];
  assign req_ready[1]     = if1.req_ready_o;
  assign resp_valid[1]    = if1.resp_valid_o;
  assign resp_rdata[1]    = if1.resp_rdata_o;
  assign resp_err[1]      = if1.resp_err_o;

  data_mem_responder #(.ADDR_WIDTH_P(10), .WAIT_CYCLES_P(1)) u_dut0 (
    .clk   (clk),
    .reset (rst[0]),
    .bus   (if0.slave)
  );

  data_mem_responder #(.ADDR_WIDTH_P(4), .WAIT_CYCLES_P(3)) u_dut1 (
    .clk   (clk),
    .reset (rst[1]),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One complete transaction with resp_ready held high; reports data, error,
  // cycles from the accept edge to resp_valid, and the accept edge time.
  task automatic xact(input int s, input logic wr, input logic bt,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err,
                      output int lat, output time tacc);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1; req_write[s] = wr; req_byte[s] = bt;
    req_addr[s]  = addr; req_wdata[s] = wdata; resp_ready[s] = 1'b1;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[s]) begin
      total++; bad++;
      $display("FAIL accept_timeout dut%0d addr=%h: req_ready=0, required 1", s, addr);
    end
    @(posedge clk);
    tacc = $time;
    @(negedge clk);
    req_valid[s] = 1'b0;
    lat = 0;
    while (!resp_valid[s] && lat < 50) begin @(negedge clk); lat++; end
    if (!resp_valid[s]) begin
      total++; bad++;
      $display("FAIL resp_timeout dut%0d addr=%h: resp_valid=0, required 1", s, addr);
    end
    rdata = resp_rdata[s];
    err   = resp_err[s];
  endtask

  task automatic test_reset();
    rst = 2'b00;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_byte[s] = 1'b0;
      req_addr[s] = '0; req_wdata[s] = '0; resp_ready[s] = 1'b0;
    end
    #1 rst = 2'b11;
    repeat (2) @(negedge clk);
    rst = 2'b00;
    for (int s = 0; s < 2; s++) begin
      total++; if (req_ready[s] !== 1'b1) begin bad++; $display("FAIL reset_ready dut%0d: got %b expected 1", s, req_ready[s]); end
      total++; if (resp_valid[s] !== 1'b0) begin bad++; $display("FAIL reset_valid dut%0d: got %b expected 0", s, resp_valid[s]); end
      total++; if (resp_rdata[s] !== 32'h0) begin bad++; $display("FAIL reset_rdata dut%0d: got %h expected 0", s, resp_rdata[s]); end
      total++; if (resp_err[s] !== 1'b0) begin bad++; $display("FAIL reset_err dut%0d: got %b expected 0", s, resp_err[s]); end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int lat; time t;
    xact(1, 1'b1, 1'b0, 32'h10, 32'h0, rd, er, lat, t);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_byte[1] = 1'b0;
    req_addr[1] = 32'h10; req_wdata[1] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1; req_valid[1] = 1'b0;
    #1;
    total++; if (req_ready[1] !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b expected 1", req_ready[1]); end
    total++; if (resp_valid[1] !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b expected 0", resp_valid[1]); end
    @(negedge clk);
    rst[1] = 1'b0;
    xact(1, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL midreset_lw: got %h expected 00000000", rd); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; time t;
    xact(0, 1'b1, 1'b0, 32'h20, 32'h11223344, rd, er, lat, t);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sw_ack: got rdata=%h err=%b expected 0/0", rd, er); end
    total++; if (lat != 1) begin bad++; $display("FAIL latency_w1: got %0d expected 1", lat); end
    xact(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h11223344 || er !== 1'b0) begin bad++; $display("FAIL lw_20: got %h err=%b expected 11223344 err=0", rd, er); end
    xact(0, 1'b0, 1'b1, 32'h23, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h00000011 || er !== 1'b0) begin bad++; $display("FAIL lbu_23: got %h err=%b expected 00000011", rd, er); end
    xact(0, 1'b0, 1'b1, 32'h20, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h00000044 || er !== 1'b0) begin bad++; $display("FAIL lbu_20: got %h err=%b expected 00000044", rd, er); end
  endtask

  task automatic test_byte_and_misaligned();
    logic [31:0] rd; logic er; int lat; time t;
    xact(0, 1'b1, 1'b1, 32'h21, 32'h123456AA, rd, er, lat, t);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL sb_ack: got rdata=%h err=%b expected 0/0", rd, er); end
    xact(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h1122AA44) begin bad++; $display("FAIL lw_after_sb: got %h expected 1122aa44", rd); end
    xact(0, 1'b0, 1'b0, 32'h22, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL lw_misaligned: got %h err=%b expected 0 err=1", rd, er); end
    xact(0, 1'b1, 1'b0, 32'h22, 32'hCAFEF00D, rd, er, lat, t);
    total++; if (rd !== 32'h0 || er !== 1'b1) begin bad++; $display("FAIL sw_misaligned: got %h err=%b expected 0 err=1", rd, er); end
    xact(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h1122AA44 || er !== 1'b0) begin bad++; $display("FAIL word_unchanged: got %h err=%b expected 1122aa44", rd, er); end
  endtask

  task automatic test_latency_hold();
    logic [31:0] rd; logic er; int lat; time t;
    xact(1, 1'b1, 1'b0, 32'h08, 32'h0BADCAFE, rd, er, lat, t);
    total++; if (lat != 3) begin bad++; $display("FAIL latency_w3: got %0d expected 3", lat); end
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_byte[1] = 1'b0;
    req_addr[1] = 32'h08; resp_ready[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    lat = 0;
    while (!resp_valid[1] && lat < 50) begin @(negedge clk); lat++; end
    total++; if (lat != 3) begin bad++; $display("FAIL hold_latency: got %0d expected 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (resp_rdata[1] !== 32'h0BADCAFE || resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got rdata=%h valid=%b ready=%b expected 0badcafe/1/0", i, resp_rdata[1], resp_valid[1], req_ready[1]);
      end
    end
    resp_ready[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (resp_valid[1] !== 1'b0 || resp_rdata[1] !== 32'h0 || req_ready[1] !== 1'b1) begin
      bad++;
      $display("FAIL hold_release: got valid=%b rdata=%h ready=%b expected 0/0/1", resp_valid[1], resp_rdata[1], req_ready[1]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat; time t;
    xact(1, 1'b1, 1'b0, 32'h40, 32'h00000055, rd, er, lat, t);
    xact(1, 1'b0, 1'b0, 32'h00, 32'h0, rd, er, lat, t);
    total++; if (rd !== 32'h00000055 || er !== 1'b0) begin bad++; $display("FAIL wrap_lw_00: got %h err=%b expected 00000055", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; time t0, t1, t2;
    xact(0, 1'b1, 1'b0, 32'h30, 32'h01020304, rd, er, lat, t0);
    xact(0, 1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat, t1);
    xact(0, 1'b0, 1'b1, 32'h32, 32'h0, rd, er, lat, t2);
    total++; if (t1 - t0 != 30 || t2 - t1 != 30) begin bad++; $display("FAIL b2b_period_w1: got %0t/%0t expected 30/30", t1 - t0, t2 - t1); end
    total++; if (rd !== 32'h00000002) begin bad++; $display("FAIL b2b_lbu_32: got %h expected 00000002", rd); end
    xact(1, 1'b1, 1'b0, 32'h04, 32'hA1B2C3D4, rd, er, lat, t0);
    xact(1, 1'b0, 1'b0, 32'h04, 32'h0, rd, er, lat, t1);
    total++; if (rd !== 32'hA1B2C3D4) begin bad++; $display("FAIL b2b_lw_04: got %h expected a1b2c3d4", rd); end
    xact(1, 1'b0, 1'b1, 32'h06, 32'h0, rd, er, lat, t2);
    total++; if (t1 - t0 != 50 || t2 - t1 != 50) begin bad++; $display("FAIL b2b_period_w3: got %0t/%0t expected 50/50", t1 - t0, t2 - t1); end
    total++; if (rd !== 32'h000000B2) begin bad++; $display("FAIL b2b_lbu_06: got %h expected 000000b2", rd); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_access();
    test_store_load();
    test_byte_and_misaligned();
    test_latency_hold();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
